// File: rtl/csa_64_driver_if.sv
// Signal bundle between the carry-select adder driver and its requester, adder and consumer.
// The slave modport is the driver's view; master is the surrounding environment's view.
interface csa_64_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        req_sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        addsum;
    logic        start;
    logic [63:0] sum_csa_64;
    logic        cout_csa_64;
    logic        overflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_neg;
    logic        rsp_ovf;
    logic        err;

    modport slave (
        input  req_valid, req_a, req_b, req_sub,
        output req_ready,
        output a, b, addsum, start,
        input  sum_csa_64, cout_csa_64, overflow,
        output rsp_valid, rsp_sum, rsp_cout, rsp_neg, rsp_ovf, err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_sub,
        input  req_ready,
        input  a, b, addsum, start,
        output sum_csa_64, cout_csa_64, overflow,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_neg, rsp_ovf, err,
        output rsp_ready
    );
endinterface

// File: rtl/csa_64_driver.sv
// Requester-side controller for the 64-bit carry-select adder with a small response FIFO.
// Define CSA_DRV_CHECK_EN to add a reference adder that flags mismatches on the sticky err output.
module csa_64_driver #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic             clock,
    input logic             reset,
    csa_64_driver_if.slave  bus
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        neg;
        logic        ovf;
    } rsp_t;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] a_q, b_q;
    logic        sub_q;
    logic        accept, push, pop;
    logic        req_ready;
    logic        ovf_calc;

    rsp_t            mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    rsp_t            head;

    assign req_ready = !reset && (state_q == StIdle) && (count_q < DepthCnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = 4'(LATENCY - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == 4'd0) state_d = StCapture;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StCapture: begin
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q   <= bus.req_a;
                b_q   <= bus.req_b;
                sub_q <= bus.req_sub;
            end
        end
    end

    // The adder's overflow pin is just sum[63]; true signed overflow needs the operand signs.
    always_comb begin
        if (sub_q) ovf_calc = (a_q[63] != b_q[63]) && (bus.sum_csa_64[63] != a_q[63]);
        else       ovf_calc = (a_q[63] == b_q[63]) && (bus.sum_csa_64[63] != a_q[63]);
    end

    assign pop = (count_q != '0) && bus.rsp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{sum:  bus.sum_csa_64, cout: bus.cout_csa_64,
                                     neg:  bus.overflow,   ovf:  ovf_calc};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.req_ready = req_ready;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.addsum    = sub_q;
    assign bus.start     = (state_q == StIssue);
    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_sum   = head.sum;
    assign bus.rsp_cout  = head.cout;
    assign bus.rsp_neg   = head.neg;
    assign bus.rsp_ovf   = head.ovf;

`ifdef CSA_DRV_CHECK_EN
    logic [64:0] ref_sum;
    logic        err_q;

    assign ref_sum = {1'b0, a_q} + {1'b0, sub_q ? ~b_q : b_q} + {64'd0, sub_q};

    always_ff @(posedge clock) begin
        if (reset)                                                     err_q <= 1'b0;
        else if (push && (ref_sum != {bus.cout_csa_64, bus.sum_csa_64})) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_csa_64_driver.sv
// Self-checking bench for csa_64_driver: directed corner cases plus randomized traffic
// against a queue-based arithmetic model; exercises err only when CSA_DRV_CHECK_EN is defined.
module tb_csa_64_driver;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc = -100;
    int   rdy_mode = 1;
    logic corrupt  = 1'b0;
    logic [64:0] adder_q = '0;
    logic [63:0] last_a, last_b;
    logic        last_sub;
    exp_t exp_q[$];

    csa_64_driver_if bus ();

    csa_64_driver #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Adder model: loads on start, result ready one cycle later (well within LATENCY).
    always @(posedge clock) begin
        if (bus.start) begin
            if (bus.addsum) adder_q <= {1'b0, bus.a} + {1'b0, ~bus.b} + 65'd1;
            else            adder_q <= {1'b0, bus.a} + {1'b0, bus.b};
        end
    end
    assign bus.sum_csa_64  = adder_q[63:0] ^ {63'd0, corrupt};
    assign bus.cout_csa_64 = adder_q[64];
    assign bus.overflow    = bus.sum_csa_64[63];

    initial forever begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                   input logic flip);
        logic [64:0] u;
        logic [64:0] s;
        exp_t r;
        if (sub) begin
            u = {1'b0, a} + {1'b0, ~b} + 65'd1;
            s = {a[63], a} - {b[63], b};
        end else begin
            u = {1'b0, a} + {1'b0, b};
            s = {a[63], a} + {b[63], b};
        end
        r.sum  = u[63:0] ^ {63'd0, flip};
        r.cout = u[64];
        r.neg  = r.sum[63];
        r.ovf  = s[64] ^ s[63];
        return r;
    endfunction

    // Monitor: records accepts, checks the start strobe/operands and every visible response head.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (bus.req_valid && bus.req_ready) begin
                exp_q.push_back(model(bus.req_a, bus.req_b, bus.req_sub, corrupt));
                last_acc = cyc;
                last_a   = bus.req_a;
                last_b   = bus.req_b;
                last_sub = bus.req_sub;
            end
            check_eq("start", {63'd0, bus.start}, {63'd0, cyc == last_acc + 1});
            if (bus.start) begin
                check_eq("a_pin", bus.a, last_a);
                check_eq("b_pin", bus.b, last_b);
                check_eq("addsum", {63'd0, bus.addsum}, {63'd0, last_sub});
            end
            if (bus.rsp_valid) begin
                check_eq("spurious_rsp", {63'd0, exp_q.size() == 0}, 64'd0);
                if (exp_q.size() != 0) begin
                    check_eq("rsp_sum", bus.rsp_sum, exp_q[0].sum);
                    check_eq("rsp_cout", {63'd0, bus.rsp_cout}, {63'd0, exp_q[0].cout});
                    check_eq("rsp_neg", {63'd0, bus.rsp_neg}, {63'd0, exp_q[0].neg});
                    check_eq("rsp_ovf", {63'd0, bus.rsp_ovf}, {63'd0, exp_q[0].ovf});
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
        int   n = 0;
        logic ok = 1'b0;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_sub   = sub;
        bus.req_valid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clock);
            ok = bus.req_ready;
            @(posedge clock);
            #1;
            n++;
        end
        bus.req_valid = 1'b0;
        check_eq("accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_eq("drain", {63'd0, n < 300}, 64'd1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h7FFF_FFFF_FFFF_FFFF;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
        check_eq("rst_start", {63'd0, bus.start}, 64'd0);
        check_eq("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check_eq("rst_a", bus.a, 64'd0);
        check_eq("rst_b", bus.b, 64'd0);
        check_eq("rst_rsp_sum", bus.rsp_sum, 64'd0);
        check_eq("rst_err", {63'd0, bus.err}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("idle_req_ready", {63'd0, bus.req_ready}, 64'd1);
        @(posedge clock);
        #1;

        // Accept-to-response latency and first-op values.
        send(64'h5, 64'h3, 1'b0);
        for (int k = 1; k <= int'(LAT) + 3; k++) begin
            @(negedge clock);
            check_eq("lat_valid", {63'd0, bus.rsp_valid}, {63'd0, k == int'(LAT) + 3});
            if (k == int'(LAT) + 3) check_eq("lat_sum", bus.rsp_sum, 64'h8);
        end
        drain();

        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        send(64'h5, 64'h3, 1'b1);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b1);
        drain();

        // Backpressure: two responses fill the FIFO, the third request must wait.
        rdy_mode = 0;
        @(posedge clock);
        #1;
        send(64'h10, 64'h20, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        fork
            send(64'h1234, 64'h4321, 1'b1);
            begin
                repeat (int'(LAT) + 6) begin
                    @(negedge clock);
                    check_eq("bp_ready", {63'd0, bus.req_ready}, 64'd0);
                end
                check_eq("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
                rdy_mode = 1;
            end
        join
        drain();

        // Reset while waiting on the adder: nothing may emerge.
        send(64'h99, 64'h1, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("rst_mid_start", {63'd0, bus.start}, 64'd0);
        check_eq("rst_mid_valid", {63'd0, bus.rsp_valid}, 64'd0);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_mid_idle", {63'd0, bus.req_ready}, 64'd1);
        repeat (int'(LAT) + 6) begin
            @(negedge clock);
            check_eq("rst_mid_norsp", {63'd0, bus.rsp_valid}, 64'd0);
        end
        @(posedge clock);
        #1;

        // Randomized traffic with random consumer stalls.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end
        rdy_mode = 1;
        drain();

`ifdef CSA_DRV_CHECK_EN
        corrupt = 1'b1;
        send(64'h100, 64'h23, 1'b0);
        drain();
        corrupt = 1'b0;
        check_eq("err_set", {63'd0, bus.err}, 64'd1);
        repeat (5) @(posedge clock);
        #1;
        check_eq("err_sticky", {63'd0, bus.err}, 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_eq("err_clear", {63'd0, bus.err}, 64'd0);
`else
        check_eq("err_tied", {63'd0, bus.err}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_64_driver.md
Name: csa_64_driver

Overview:
- Requester-side controller for the 64-bit carry-select adder.
- Accepts add/subtract requests over a valid/ready handshake and drives the adder's operand, start and add/sub pins.
- Waits a fixed number of cycles for the adder's result, then captures it into a small response FIFO.
- Also computes true two's-complement overflow, because the adder's overflow pin is only the sign bit of the sum.

Parameters:
LATENCY, 2, cycles from the start pulse until the adder's sum/cout outputs are stable and get sampled; legal range 1..15
FIFO_DEPTH, 2, response FIFO entries; power of two, minimum 2

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  upstream request valid
req_ready  output  1  driver can accept a request
req_a  input  64  operand A
req_b  input  64  operand B
req_sub  input  1  1 = A-B, 0 = A+B
a  output  64  operand A to adder
b  output  64  operand B to adder (uninverted; the adder inverts it)
addsum  output  1  subtract select to adder
start  output  1  one-cycle operand-load strobe to adder
sum_csa_64  input  64  adder sum
cout_csa_64  input  1  adder carry-out
overflow  input  1  adder sign flag (sum bit 63)
rsp_valid  output  1  response available
rsp_ready  input  1  downstream accepts response
rsp_sum  output  64  result, modulo 2^64
rsp_cout  output  1  captured carry-out
rsp_neg  output  1  captured adder overflow pin (sign)
rsp_ovf  output  1  true signed overflow
err  output  1  sticky check error (see Optional Feature)

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high on clock rising edge.
- Reset values: state IDLE; a=0, b=0, addsum=0, start=0; req_ready=0 while reset is high; FIFO empty; rsp_valid=0; rsp_* data=0; err=0.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - req_ready = (fifo_count < FIFO_DEPTH).
  - On req_valid && req_ready: register req_a→a, req_b→b, req_sub→addsum; go to ISSUE.
- ISSUE:
  - start=1 for exactly this one cycle.
  - Wait counter loads LATENCY-1; go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At 0, go to CAPTURE.
- CAPTURE:
  - Push {sum_csa_64, cout_csa_64, overflow, ovf_calc} into the FIFO; return to IDLE.
- Operand stability: a, b and addsum hold from ISSUE through CAPTURE inclusive. start is 0 in all states except ISSUE.
- req_ready is 0 in ISSUE, WAIT and CAPTURE. Only one operation is in flight at a time.
- Throughput: one operation per LATENCY+3 cycles. Accept-to-rsp_valid latency: LATENCY+3 cycles.
- ovf_calc:
  - Add: (a[63]==b[63]) && (sum[63]!=a[63]).
  - Sub: (a[63]!=b[63]) && (sum[63]!=a[63]).
- FIFO:
  - rsp_valid = (count != 0); rsp_* shows the head entry, registered.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Push never occurs when full (guaranteed by req_ready gating). Pointers wrap modulo FIFO_DEPTH.
- Head stability: while rsp_valid=1 and rsp_ready=0, rsp_* must not change.
- Reset mid-operation: the in-flight op is abandoned, the FIFO is flushed, and start drops on the same edge. No partial response is emitted.

Optional Feature:
- Macro: CSA_DRV_CHECK_EN.
- Defined:
  - The driver computes a behavioural reference: a+b, or a-b for subtract, in 65 bits.
  - At CAPTURE it compares sum and carry against the adder's values.
  - Any mismatch sets err, which stays at 1 until reset.
- Undefined: err is tied to 0 and no reference adder is synthesised.

Test Plan:
- Add a=0x0000_0000_0000_0005, b=0x3, rsp_ready=1 → start pulse 1 cycle after accept; rsp_sum=0x8, rsp_cout=0, rsp_ovf=0, rsp_neg=0; rsp_valid exactly LATENCY+3 cycles after accept.
- Add a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 → rsp_sum=0x8000_0000_0000_0000, rsp_ovf=1, rsp_neg=1, rsp_cout=0.
- Add a=0xFFFF_FFFF_FFFF_FFFF, b=0x1 → rsp_sum=0, rsp_cout=1, rsp_ovf=0.
- Sub a=0x5, b=0x3 → addsum=1, b pin=0x3, rsp_sum=0x2, rsp_cout=1, rsp_ovf=0. Sub a=0x8000_0000_0000_0000, b=0x1 → rsp_ovf=1.
- Backpressure: rsp_ready=0, three back-to-back requests with FIFO_DEPTH=2 → two complete; req_ready stays 0 after the second capture; head data stable. Raise rsp_ready → responses pop in order; third request accepted.
- Reset asserted during WAIT → next cycle start=0, rsp_valid=0, state IDLE, no response emitted. With CSA_DRV_CHECK_EN, force sum_csa_64 wrong at CAPTURE → err=1 and held until reset.
